key_pulse_gen: RTL and testbench



---
 rtl/key_pulse_gen.sv | 153 +++++++++++++++
 tb/tb_key_pulse_gen.sv | 136 +++++++++++++
 2 files changed

// File: rtl/key_pulse_gen.sv
// key_pulse_gen
//   Per-key conditioner for raw push-button inputs. Each channel has a 2-flop
//   synchroniser, a debounce counter and a 3-state hold FSM. It emits
//   registered single-cycle press / release / long-press pulses.
//
//   Optional build macro: KEY_AUTOREPEAT_EN
//     defined   : while a key is long-held, o_press repeats every REPEAT_CYCLES
//     undefined : LONG state stays silent until release
//
// Ports
//   clk       in   system clock, rising edge
//   nrst      in   synchronous reset, ACTIVE-HIGH despite the name
//   i_key     in   [N_KEYS] raw asynchronous key levels, 1 = pressed
//   o_level   out  [N_KEYS] debounced key level
//   o_press   out  [N_KEYS] one-cycle pulse on accepted press (and repeats)
//   o_release out  [N_KEYS] one-cycle pulse on accepted release
//   o_long    out  [N_KEYS] one-cycle pulse when a hold reaches LONG_CYCLES
//
// Hold FSM (per channel)
//   state      | meaning
//   ST_IDLE    | debounced key released
//   ST_PRESSED | debounced key down, hold counter running toward long-press
//   ST_LONG    | long-press reported; counter reused as repeat timer

module key_pulse_gen #(
  parameter int N_KEYS        = 3,
  parameter int DB_CYCLES     = 4,
  parameter int LONG_CYCLES   = 32,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [N_KEYS-1:0] i_key,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_long
);

  localparam int DW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int HW = $clog2(LONG_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_LONG    = 2'd2;

  // The repeat timer shares the hold counter, so the repeat interval must fit in it.
  if (DB_CYCLES < 2 || LONG_CYCLES <= DB_CYCLES ||
      REPEAT_CYCLES < 1 || REPEAT_CYCLES > LONG_CYCLES + 1) begin : g_bad_params
    $error("key_pulse_gen: illegal parameter combination");
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic          s1, s2, level;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold;
    logic [1:0]    st;
    logic          press, rel, lng;
    logic          mism, accept, rise, fall;

    assign mism   = (s2 != level);
    assign accept = mism && (db_cnt == DB_LAST);
    assign rise   = accept && s2;
    assign fall   = accept && !s2;

    always_ff @(posedge clk) begin
      if (nrst) begin
        s1     <= 1'b0;
        s2     <= 1'b0;
        level  <= 1'b0;
        db_cnt <= '0;
        hold   <= '0;
        st     <= ST_IDLE;
        press  <= 1'b0;
        rel    <= 1'b0;
        lng    <= 1'b0;
      end else begin
        s1    <= i_key[k];
        s2    <= s1;
        press <= 1'b0;
        rel   <= 1'b0;
        lng   <= 1'b0;

        if (!mism) begin
          db_cnt <= '0;
        end else if (accept) begin
          level  <= s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end

        // FSM reacts to the level change being accepted this edge, so the
        // pulse lands on the same edge that o_level changes.
        case (st)
          ST_IDLE: begin
            if (rise) begin
              st    <= ST_PRESSED;
              press <= 1'b1;
              hold  <= '0;
            end
          end
          ST_PRESSED: begin
            // Release takes priority over reaching the long-press limit.
            if (fall) begin
              st   <= ST_IDLE;
              rel  <= 1'b1;
              hold <= '0;
            end else if (hold >= HOLD_LAST) begin
              st   <= ST_LONG;
              lng  <= 1'b1;
              hold <= '0;
            end else begin
              hold <= hold + 1'b1;
            end
          end
          ST_LONG: begin
            if (fall) begin
              st   <= ST_IDLE;
              rel  <= 1'b1;
              hold <= '0;
            end else begin
`ifdef KEY_AUTOREPEAT_EN
              if (hold >= REP_LAST) begin
                press <= 1'b1;
                hold  <= '0;
              end else begin
                hold <= hold + 1'b1;
              end
`else
              hold <= '0;
`endif
            end
          end
          default: begin
            st   <= ST_IDLE;
            hold <= '0;
          end
        endcase
      end
    end

    assign o_level[k]   = level;
    assign o_press[k]   = press;
    assign o_release[k] = rel;
    assign o_long[k]    = lng;
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen at default parameters.
// Edge numbering: keys change just after an edge; the next rising edge is edge 0.

module tb_key_pulse_gen;

  localparam int DB   = 4;
  localparam int LONG = 32;
  localparam int REP  = 8;

  logic       clk = 1'b0;
  logic       nrst;
  logic [2:0] i_key;
  logic [2:0] o_level, o_press, o_release, o_long;

  int n_cmp = 0;
  int n_err = 0;

  key_pulse_gen #(
    .N_KEYS(3), .DB_CYCLES(DB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .nrst(nrst), .i_key(i_key),
    .o_level(o_level), .o_press(o_press), .o_release(o_release), .o_long(o_long)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_level"},   32'(o_level),   32'd0);
    check_val({tag, "_press"},   32'(o_press),   32'd0);
    check_val({tag, "_release"}, 32'(o_release), 32'd0);
    check_val({tag, "_long"},    32'(o_long),    32'd0);
  endtask

  task automatic settle();
    i_key = 3'b000;
    repeat (15) tick();
  endtask

  // Hold key `b` for `hold` cycles starting before edge 0, checking every
  // output on every edge against hand-derived event edges.
  task automatic press_run(input string tag, input int b, input int hold, input int n_edges);
    int  rise_e, fall_e, long_e;
    bit  rose, exp_p, exp_r, exp_l, exp_v;
    logic [2:0] m;
    m      = 3'b001 << b;
    rose   = (hold >= DB);
    rise_e = DB + 1;
    fall_e = hold + DB + 1;
    long_e = DB + 1 + LONG;
    i_key  = m;
    for (int e = 0; e < n_edges; e++) begin
      if (e == hold) i_key = 3'b000;
      tick();
      exp_v = rose && (e >= rise_e) && (e < fall_e);
      exp_r = rose && (e == fall_e);
      exp_l = rose && (fall_e > long_e) && (e == long_e);
      exp_p = rose && (e == rise_e);
`ifdef KEY_AUTOREPEAT_EN
      if (rose && fall_e > long_e && e > long_e && e < fall_e && ((e - long_e) % REP) == 0)
        exp_p = 1'b1;
`endif
      check_val($sformatf("%s_level_e%0d", tag, e),   32'(o_level),   32'(exp_v ? m : 3'b000));
      check_val($sformatf("%s_press_e%0d", tag, e),   32'(o_press),   32'(exp_p ? m : 3'b000));
      check_val($sformatf("%s_release_e%0d", tag, e), 32'(o_release), 32'(exp_r ? m : 3'b000));
      check_val($sformatf("%s_long_e%0d", tag, e),    32'(o_long),    32'(exp_l ? m : 3'b000));
    end
  endtask

  initial begin
    // Reset with all keys pressed: outputs stay 0, then a fresh press on all keys.
    nrst  = 1'b1;
    i_key = 3'b111;
    tick();
    check_all_zero("rst_c1");
    tick();
    check_all_zero("rst_c2");
    nrst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check_val($sformatf("rst_press_e%0d", e),   32'(o_press),   32'((e == 6) ? 3'b111 : 3'b000));
      check_val($sformatf("rst_level_e%0d", e),   32'(o_level),   32'((e >= 6) ? 3'b111 : 3'b000));
      check_val($sformatf("rst_release_e%0d", e), 32'(o_release), 32'd0);
    end
    settle();
    check_val("rst_released_level", 32'(o_level), 32'd0);

    // Short press on key 1, held 10 cycles.
    press_run("short", 1, 10, 20);
    settle();

    // 3-cycle glitch on key 0: below the debounce threshold.
    press_run("glitch", 0, 3, 14);
    settle();

    // Long hold of 50 cycles on key 2.
    press_run("long", 2, 50, 60);
    settle();

    // Release lands exactly on the long-press edge on key 0: release wins.
    press_run("bound", 0, LONG, LONG + DB + 6);
    settle();

    // Reset mid-hold on key 2: no release for the aborted hold, fresh press later.
    i_key = 3'b100;
    repeat (20) tick();
    check_val("mid_level_before", 32'(o_level), 32'(3'b100));
    nrst = 1'b1;
    tick();
    check_all_zero("mid_rst");
    nrst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_val($sformatf("mid_press_e%0d", e),   32'(o_press),   32'((e == 6) ? 3'b100 : 3'b000));
      check_val($sformatf("mid_release_e%0d", e), 32'(o_release), 32'd0);
      check_val($sformatf("mid_long_e%0d", e),    32'(o_long),    32'd0);
    end
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
